// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: write/read/status bundle for sync_fifo_param.
// master = producer/consumer side, slave = FIFO side.
interface sync_fifo_param_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4
);
  logic                     Clear_in;
  logic [DATA_WIDTH-1:0]    Data_in;
  logic                     WriteEn_in;
  logic                     Full_out;
  logic                     AlmostFull_out;
  logic [DATA_WIDTH-1:0]    Data_out;
  logic                     ReadEn_in;
  logic                     Empty_out;
  logic                     AlmostEmpty_out;
  logic [ADDRESS_WIDTH:0]   Count_out;
  logic                     Overflow_out;
  logic                     Underflow_out;

  modport master (
    output Clear_in, Data_in, WriteEn_in, ReadEn_in,
    input  Full_out, AlmostFull_out, Data_out, Empty_out,
    input  AlmostEmpty_out, Count_out, Overflow_out, Underflow_out
  );

  modport slave (
    input  Clear_in, Data_in, WriteEn_in, ReadEn_in,
    output Full_out, AlmostFull_out, Data_out, Empty_out,
    output AlmostEmpty_out, Count_out, Overflow_out, Underflow_out
  );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with fill count, thresholds, sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4,
  parameter int AFULL_LEVEL   = (1 << ADDRESS_WIDTH) - 2,
  parameter int AEMPTY_LEVEL  = 2
) (
  input logic              Clk,
  input logic              Reset_in,
  sync_fifo_param_if.slave bus
);
  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam int CW    = ADDRESS_WIDTH + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AFULL_LEVEL);
  localparam logic [CW-1:0] AE_C   = CW'(AEMPTY_LEVEL);

  logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
  logic [ADDRESS_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDRESS_WIDTH-1:0] rptr_q, rptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0]    dout_q, dout_d;
  logic full_q, full_d;
  logic afull_q, afull_d;
  logic empty_q, empty_d;
  logic aempty_q, aempty_d;
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;
  logic wr_acc, rd_acc, pop;

  always_comb begin
    wr_acc  = bus.WriteEn_in & ~full_q;
    rd_acc  = bus.ReadEn_in & ~empty_q;
    wptr_d  = wptr_q + ADDRESS_WIDTH'(wr_acc);
    count_d = count_q;
    if (wr_acc & ~rd_acc)
      count_d = count_q + CW'(1);
    else if (rd_acc & ~wr_acc)
      count_d = count_q - CW'(1);
`ifdef SYNC_FIFO_FWFT_EN
    // prefetch when memory holds a word beyond Data_out and the slot frees
    pop = (count_q != {{ADDRESS_WIDTH{1'b0}}, ~empty_q})
        & (empty_q | rd_acc);
    empty_d = ~pop & (empty_q | rd_acc);
`else
    pop     = rd_acc;
    empty_d = (count_d == '0);
`endif
    rptr_d   = rptr_q + ADDRESS_WIDTH'(pop);
    dout_d   = pop ? mem_q[rptr_q] : dout_q;
    full_d   = (count_d == FULL_C);
    afull_d  = (count_d >= AF_C);
    aempty_d = (count_d <= AE_C);
    ovf_d    = ovf_q | (bus.WriteEn_in & full_q);
    unf_d    = unf_q | (bus.ReadEn_in & empty_q);
  end

  always_ff @(posedge Clk) begin
    if (wr_acc & ~bus.Clear_in)
      mem_q[wptr_q] <= bus.Data_in;
  end

  always_ff @(posedge Clk or posedge Reset_in) begin
    if (Reset_in) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else if (bus.Clear_in) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign bus.Full_out        = full_q;
  assign bus.AlmostFull_out  = afull_q;
  assign bus.Data_out        = dout_q;
  assign bus.Empty_out       = empty_q;
  assign bus.AlmostEmpty_out = aempty_q;
  assign bus.Count_out       = count_q;
  assign bus.Overflow_out    = ovf_q;
  assign bus.Underflow_out   = unf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed + random stimulus against a queue model.
// Targets the default (registered-read) build, DEPTH=16, 8-bit.
module tb_sync_fifo_param;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mq [$];
  logic [DW-1:0] mdout = '0;
  bit movf = 0;
  bit munf = 0;

  sync_fifo_param_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  sync_fifo_param #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
    .AFULL_LEVEL(AF), .AEMPTY_LEVEL(AE)
  ) dut (
    .Clk(clk),
    .Reset_in(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".count"}, 64'(bus.Count_out), 64'(n));
    chk({tag, ".full"}, 64'(bus.Full_out), 64'(n == DEPTH));
    chk({tag, ".afull"}, 64'(bus.AlmostFull_out), 64'(n >= AF));
    chk({tag, ".empty"}, 64'(bus.Empty_out), 64'(n == 0));
    chk({tag, ".aempty"}, 64'(bus.AlmostEmpty_out), 64'(n <= AE));
    chk({tag, ".dout"}, 64'(bus.Data_out), 64'(mdout));
    chk({tag, ".ovf"}, 64'(bus.Overflow_out), 64'(movf));
    chk({tag, ".unf"}, 64'(bus.Underflow_out), 64'(munf));
  endtask

  task automatic model_reset();
    mq.delete();
    mdout = '0;
    movf = 0;
    munf = 0;
  endtask

  task automatic model_edge(input bit w, input bit r, input bit c,
                            input logic [DW-1:0] d);
    bit full, empty;
    if (c) begin
      model_reset();
      return;
    end
    full = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    if (w && full) movf = 1;
    if (r && empty) munf = 1;
    if (r && !empty) mdout = mq.pop_front();
    if (w && !full) mq.push_back(d);
  endtask

  task automatic step(input string tag, input bit w, input bit r,
                      input bit c, input logic [DW-1:0] d);
    bus.WriteEn_in = w;
    bus.ReadEn_in = r;
    bus.Clear_in = c;
    bus.Data_in = d;
    @(posedge clk);
    model_edge(w, r, c, d);
    @(negedge clk);
    check_all(tag);
    bus.WriteEn_in = 1'b0;
    bus.ReadEn_in = 1'b0;
    bus.Clear_in = 1'b0;
    bus.Data_in = '0;
  endtask

  task automatic fill_to(input string tag, input int n);
    while (mq.size() < n)
      step(tag, 1'b1, 1'b0, 1'b0, DW'($urandom));
  endtask

  initial begin
    bus.WriteEn_in = 1'b0;
    bus.ReadEn_in = 1'b0;
    bus.Clear_in = 1'b0;
    bus.Data_in = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    for (int i = 0; i < 16; i++)
      step("fill", 1'b1, 1'b0, 1'b0, DW'(i));
    step("overflow", 1'b1, 1'b0, 1'b0, 8'hAA);
    for (int i = 0; i < 16; i++)
      step("drain", 1'b0, 1'b1, 1'b0, 8'h00);

    step("rw_empty", 1'b1, 1'b1, 1'b0, 8'h55);
    step("read55", 1'b0, 1'b1, 1'b0, 8'h00);
    step("clear1", 1'b0, 1'b0, 1'b1, 8'h00);

    fill_to("fill16b", 16);
    step("rw_full", 1'b1, 1'b1, 1'b0, 8'hBB);
    step("clear2", 1'b0, 1'b0, 1'b1, 8'h00);

    fill_to("fill15", 15);
    for (int i = 0; i < 100; i++)
      step("stream", 1'b1, 1'b1, 1'b0, DW'($urandom));
    for (int i = 0; i < 15; i++)
      step("stream_drain", 1'b0, 1'b1, 1'b0, 8'h00);

    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 40) == 0), DW'($urandom));

    step("clear3", 1'b0, 1'b0, 1'b1, 8'h00);
    fill_to("fill9", 9);
    #1 rst = 1'b1;
    #1 model_reset();
    check_all("async_rst");
    #1 rst = 1'b0;
    step("post_rst_idle", 1'b0, 1'b0, 1'b0, 8'h00);
    step("wr3c", 1'b1, 1'b0, 1'b0, 8'h3C);
    step("rd3c", 1'b0, 1'b1, 1'b0, 8'h00);

    step("unf_set", 1'b0, 1'b1, 1'b0, 8'h00);
    fill_to("fill5", 5);
    step("clear_prio", 1'b1, 1'b1, 1'b1, 8'h77);
    step("wr11", 1'b1, 1'b0, 1'b0, 8'h11);
    step("rd11", 1'b0, 1'b1, 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
